// File: rtl/svm_dot_accum.sv
// svm_dot_accum: sums N_FEAT signed products from the multiplier stage into a wide
// accumulator, adds the SVM bias, saturates to DATA_WIDTH and registers the decision
// value together with a class bit.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   start_i       one-cycle pulse opening a new vector (ignored while busy)
//   prod_valid_i  prod_data_i is valid this cycle (only used while accumulating)
//   prod_data_i   signed product, DATA_WIDTH bits
//   bias_i        signed bias, sampled in the bias-add cycle
//   acc_out_o     saturated signed decision value, held until the next done
//   class_out_o   1 when acc_out_o >= 0
//   overflow_o    last result was clipped by saturation
//   done_o        one-cycle pulse, result outputs updated on the same edge
//   busy_o        high whenever a vector is in flight
//
// ACC_WIDTH must be at least DATA_WIDTH + clog2(N_FEAT) + 1 so that N_FEAT full-scale
// products plus the bias never wrap internally; N_FEAT must lie in 2..255 and fit in
// CNT_WIDTH.
module svm_dot_accum #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned N_FEAT     = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  prod_valid_i,
  input  logic [DATA_WIDTH-1:0] prod_data_i,
  input  logic [DATA_WIDTH-1:0] bias_i,
  output logic [DATA_WIDTH-1:0] acc_out_o,
  output logic                  class_out_o,
  output logic                  overflow_o,
  output logic                  done_o,
  output logic                  busy_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StBias  = 2'd2;
  localparam logic [1:0] StSat   = 2'd3;

  localparam int unsigned ExtW = ACC_WIDTH - DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(N_FEAT - 1);

  localparam logic [DATA_WIDTH-1:0] SatMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SatMin = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]            state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_out_q, acc_out_d;
  logic                  class_q, class_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;

  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  bias_ext;
  logic [ExtW:0]         acc_top;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] sat_val;

  assign prod_ext = {{ExtW{prod_data_i[DATA_WIDTH-1]}}, prod_data_i};
  assign bias_ext = {{ExtW{bias_i[DATA_WIDTH-1]}}, bias_i};

  // The value fits in DATA_WIDTH exactly when every bit from the result sign bit up
  // to the accumulator MSB agrees.
  assign acc_top  = acc_q[ACC_WIDTH-1:DATA_WIDTH-1];
  assign in_range = (&acc_top) | ~(|acc_top);

  always_comb begin
    if (in_range) begin
      sat_val = acc_q[DATA_WIDTH-1:0];
    end else if (acc_q[ACC_WIDTH-1]) begin
      sat_val = SatMin;
    end else begin
      sat_val = SatMax;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    acc_out_d = acc_out_q;
    class_d   = class_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        // prod_valid_i is deliberately ignored here, even alongside start_i.
        if (start_i) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (prod_valid_i) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = StBias;
          end
        end
      end
      StBias: begin
        acc_d   = acc_q + bias_ext;
        state_d = StSat;
      end
      StSat: begin
        acc_out_d = sat_val;
        ovf_d     = ~in_range;
        class_d   = ~sat_val[DATA_WIDTH-1];
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      acc_out_q <= '0;
      class_q   <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      acc_out_q <= acc_out_d;
      class_q   <= class_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign acc_out_o   = acc_out_q;
  assign class_out_o = class_q;
  assign overflow_o  = ovf_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_svm_dot_accum.sv
// Scoreboard bench for svm_dot_accum with N_FEAT = 4: stimulus pushes the expected
// decision (from a plain-arithmetic model) and a monitor pops on each done pulse.
module tb_svm_dot_accum;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 40;
  localparam int unsigned NF = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          prod_valid_i = 1'b0;
  logic [DW-1:0] prod_data_i = '0;
  logic [DW-1:0] bias_i = '0;
  logic [DW-1:0] acc_out_o;
  logic          class_out_o;
  logic          overflow_o;
  logic          done_o;
  logic          busy_o;

  svm_dot_accum #(
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .N_FEAT    (NF),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .prod_valid_i(prod_valid_i),
    .prod_data_i (prod_data_i),
    .bias_i      (bias_i),
    .acc_out_o   (acc_out_o),
    .class_out_o (class_out_o),
    .overflow_o  (overflow_o),
    .done_o      (done_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] acc;
    logic        cls;
    logic        ovf;
    longint      cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  logic [31:0] pq[$];
  logic [31:0] hold_acc = '0;
  logic        hold_cls = 1'b0;
  logic        hold_ovf = 1'b0;
  logic        prev_done = 1'b0;
  bit          mon_en = 1'b0;
  int          npass = 0;
  int          ntotal = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference: exact integer sum of products plus bias, clamped to the 32-bit range.
  function automatic exp_t model(input logic [31:0] b, input longint last_drive);
    longint s;
    exp_t   e;
    s = 0;
    foreach (pq[i]) s += longint'($signed(pq[i]));
    s += longint'($signed(b));
    if (s > 64'sd2147483647) begin
      e.acc = 32'h7fff_ffff;
      e.ovf = 1'b1;
    end else if (s < -64'sd2147483648) begin
      e.acc = 32'h8000_0000;
      e.ovf = 1'b1;
    end else begin
      e.acc = 32'(s);
      e.ovf = 1'b0;
    end
    e.cls = (s >= 0);
    // Driven after edge k, captured at k+1, result registered at k+3.
    e.cyc = last_drive + 3;
    return e;
  endfunction

  function automatic void set4(input int a, input int b, input int c, input int d);
    pq.delete();
    pq.push_back(32'(a));
    pq.push_back(32'(b));
    pq.push_back(32'(c));
    pq.push_back(32'(d));
  endfunction

  // Entered and left 1 time unit after a rising edge. Returns right after the edge
  // that registers done, so a following call issues start in the cycle after done.
  task automatic run_vec(input logic [31:0] b, input int gap_mode, input bit extra_start);
    longint dc;
    int     gap;
    dc = 0;
    start_i      = 1'b1;
    bias_i       = b;
    prod_valid_i = 1'b1;  // must be ignored alongside start in idle
    prod_data_i  = $urandom;
    @(posedge clk); #1;
    start_i = 1'b0;
    foreach (pq[i]) begin
      gap = (gap_mode >= 0) ? gap_mode : int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        prod_valid_i = 1'b0;
        prod_data_i  = $urandom;
        start_i      = extra_start && (i == 1) && (g == 0);
        @(posedge clk); #1;
        start_i = 1'b0;
      end
      prod_valid_i = 1'b1;
      prod_data_i  = pq[i];
      dc = cyc;
      @(posedge clk); #1;
    end
    prod_valid_i = 1'b0;
    prod_data_i  = $urandom;
    sb.push_back(model(b, dc));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rand_prods();
    int mode;
    pq.delete();
    mode = int'($urandom_range(0, 2));
    for (int i = 0; i < int'(NF); i++) begin
      case (mode)
        0:       pq.push_back($urandom);
        1:       pq.push_back(32'(int'($urandom_range(0, 2000)) - 1000));
        default: pq.push_back($urandom_range(0, 1) ? 32'h7fff_ffff : 32'h8000_0000);
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (done_o) begin
        if (prev_done) check("done_twice", 64'(prev_done), 64'd0);
        if (sb.size() == 0) begin
          check("spurious_done", 64'(done_o), 64'd0);
        end else begin
          me = sb.pop_front();
          check("acc_out", 64'(acc_out_o), 64'(me.acc));
          check("class_out", 64'(class_out_o), 64'(me.cls));
          check("overflow", 64'(overflow_o), 64'(me.ovf));
          check("done_cycle", 64'(cyc), 64'(me.cyc));
          hold_acc = me.acc;
          hold_cls = me.cls;
          hold_ovf = me.ovf;
        end
      end else begin
        check("hold_acc", 64'(acc_out_o), 64'(hold_acc));
        check("hold_class", 64'(class_out_o), 64'(hold_cls));
        check("hold_ovf", 64'(overflow_o), 64'(hold_ovf));
      end
    end
    prev_done = done_o;
  end

  initial begin
    int wait_cnt;
    repeat (3) @(posedge clk);
    #1;
    check("rst_acc_out", 64'(acc_out_o), 64'd0);
    check("rst_class", 64'(class_out_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Idle with random products and no start.
    for (int i = 0; i < 20; i++) begin
      prod_valid_i = 1'($urandom_range(0, 1));
      prod_data_i  = $urandom;
      @(posedge clk); #1;
      check("idle_busy", 64'(busy_o), 64'd0);
      check("idle_done", 64'(done_o), 64'd0);
      check("idle_acc", 64'(acc_out_o), 64'd0);
    end
    prod_valid_i = 1'b0;

    set4(10, -3, 7, 1);
    run_vec(32'(-5), 0, 1'b0);

    set4(-100, -200, -300, 50);
    run_vec(32'd0, 2, 1'b1);

    set4(32'h7fff_ffff, 32'h7fff_ffff, 32'h7fff_ffff, 32'h7fff_ffff);
    run_vec(32'd1, 0, 1'b0);
    set4(0, 0, 0, 0);
    run_vec(32'd0, 0, 1'b0);

    set4(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    run_vec(32'hffff_ffff, 0, 1'b0);

    // Abort mid-vector with reset.
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prod_valid_i = 1'b1;
      prod_data_i  = $urandom;
      @(posedge clk); #1;
    end
    check("pre_rst_busy", 64'(busy_o), 64'd1);
    prod_valid_i = 1'b0;
    rst = 1'b1;
    hold_acc = '0;
    hold_cls = 1'b0;
    hold_ovf = 1'b0;
    #1;
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_done", 64'(done_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_acc", 64'(acc_out_o), 64'd0);
    check("abort_ovf", 64'(overflow_o), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_busy_after", 64'(busy_o), 64'd0);

    // Back-to-back vectors, then random traffic.
    set4(1000, 2000, -500, 7);
    run_vec(32'd3, 0, 1'b0);
    set4(-1, -2, -3, -4);
    run_vec(32'd5, 0, 1'b0);
    for (int v = 0; v < 20; v++) begin
      rand_prods();
      run_vec($urandom, -1, 1'($urandom_range(0, 1)));
    end

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
